// File: rtl/atomic_alu_pkg.sv
// Shared definitions for the atomic ALU sequencer: opcodes, FSM state codes,
// and helpers that pull fields out of an encoded command word.
package atomic_alu_pkg;

  // Widest command word the field helpers accept (covers NREG up to 256).
  localparam int CMD_MAX_W = 32;

  typedef enum logic [2:0] {
    OP_0   = 3'd0,
    OP_SUB = 3'd1,
    OP_2   = 3'd2,
    OP_3   = 3'd3,
    OP_4   = 3'd4,
    OP_5   = 3'd5,
    OP_6   = 3'd6,
    OP_CAS = 3'd7
  } op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Opcode sits directly above the three register fields.
  function automatic logic [2:0] cmd_op(input logic [CMD_MAX_W-1:0] c, input int aw);
    return c[3*aw +: 3];
  endfunction

  // Register field by slot: 2 = ra, 1 = rb, 0 = rc.
  function automatic logic [7:0] cmd_reg(input logic [CMD_MAX_W-1:0] c, input int aw,
                                         input int slot);
    return 8'((c >> (aw * slot)) & ((1 << aw) - 1));
  endfunction

endpackage

// File: rtl/atomic_regfile.sv
// NREG x DATA_W register file: two read ports, a debug read port and two
// write ports. Write port 1 carries the CAS status and wins on collision.
module atomic_regfile
  import atomic_alu_pkg::*;
#(
  parameter  int NREG   = 8,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1
);

  logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;

  // Next contents: port 0 first, port 1 applied last so it overrides.
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[wa0] = wd0;
    if (we1) mem_d[wa1] = wd1;
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rd0_data = mem_q[rd0_addr];
  assign rd1_data = mem_q[rd1_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/atomic_exec_unit.sv
// Command sequencer around an external combinational ALU. Opcode 7 runs as
// a compare-and-swap whose success lands in the top register.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | ready; on handshake latch command and load ALU operands
//   ST_EXEC  | capture ALU result and flags
//   ST_WRITE | write back (or CAS swap + status), pulse done
module atomic_exec_unit
  import atomic_alu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 8,
  localparam int ADDR_W = $clog2(NREG),
  localparam int CMD_W  = 3 + 3 * ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_o,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic [3:0]        flags,
  output logic              done,
  output logic              cas_ok,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d, alu_op_q, alu_op_d;
  logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  logic [3:0]        flags_q, flags_d;
  logic              cas_ok_q, cas_ok_d;

  logic [2:0]        cmd_op_w;
  logic [ADDR_W-1:0] cmd_ra_w, cmd_rb_w;
  logic [ADDR_W-1:0] cmd_rc_w;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic              is_write, is_cas, cas_hit;
  logic              we0, we1;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;

  assign cmd_op_w = cmd_op(CMD_MAX_W'(cmd), ADDR_W);
  assign cmd_ra_w = ADDR_W'(cmd_reg(CMD_MAX_W'(cmd), ADDR_W, 2));
  assign cmd_rb_w = ADDR_W'(cmd_reg(CMD_MAX_W'(cmd), ADDR_W, 1));
  assign cmd_rc_w = ADDR_W'(cmd_reg(CMD_MAX_W'(cmd), ADDR_W, 0));

  assign is_write = (state_q == ST_WRITE);
  assign is_cas   = (op_q == OP_CAS);
  assign cas_hit  = flags_q[1];

  // Read port 0 serves ra at acceptance and the CAS swap value R[rc] in WRITE.
  assign rd0_addr = is_write ? rc_q : cmd_ra_w;

  assign we0 = is_write && (!is_cas || cas_hit);
  assign wa0 = is_cas ? ra_q : rc_q;
  assign wd0 = is_cas ? rd0_data : res_q;
  assign we1 = is_write && is_cas;
  assign wa1 = ADDR_W'(NREG - 1);
  assign wd1 = {{(DATA_W - 1){1'b0}}, cas_hit};

  atomic_regfile #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd1_addr (cmd_rb_w),
    .rd1_data (rd1_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1)
  );

  // Sequencer next-state and latch updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    res_d    = res_q;
    flags_d  = flags_q;
    cas_ok_d = cas_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op_w;
          ra_d     = cmd_ra_w;
          rb_d     = cmd_rb_w;
          rc_d     = cmd_rc_w;
          alu_a_d  = rd0_data;
          alu_b_d  = rd1_data;
          // CAS compares by subtracting; Z then means R[ra] == R[rb].
          alu_op_d = (cmd_op_w == OP_CAS) ? OP_SUB : cmd_op_w;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_y;
        flags_d = {alu_o, alu_c, alu_z, alu_n};
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cas_ok_d = is_cas && cas_hit;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      cas_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      cas_ok_q <= cas_ok_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = is_write;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign flags     = flags_q;
  assign cas_ok    = cas_ok_q;

endmodule

// File: tb/tb_atomic_exec_unit.sv
// Bench for atomic_exec_unit: an ALU model drives the ALU inputs, and a
// register-array reference model predicts every command's outcome.
module tb_atomic_exec_unit;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int ADDR_W = 3;
  localparam int CMD_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic              alu_o, alu_c, alu_z, alu_n;
  logic [3:0]        flags;
  logic              done;
  logic              cas_ok;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  logic [31:0] imm;
  logic [31:0] m_reg [NREG];
  logic [3:0]  m_flags;
  logic        m_cas_ok;
  int checks = 0;
  int errors = 0;

  atomic_exec_unit dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
    .flags(flags), .done(done), .cas_ok(cas_ok), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 load immediate.
  function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] im);
    logic [32:0] w;
    logic [31:0] y;
    logic o, c;
    o = 1'b0; c = 1'b0; w = '0; y = '0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; y = w[31:0]; c = w[32];
                  o = (a[31] == b[31]) && (y[31] != a[31]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; y = w[31:0]; c = w[32];
                  o = (a[31] != b[31]) && (y[31] != a[31]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a + 32'd1;
      3'd6: y = im;
      default: y = '0;
    endcase
    return {y, o, c, (y == 32'd0), y[31]};
  endfunction

  assign {alu_y, alu_o, alu_c, alu_z, alu_n} = alu_fn(alu_op, alu_a, alu_b, imm);

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_flags = '0;
    m_cas_ok = 1'b0;
  endtask

  // Issue one command, check its handshake timing and the full resulting state.
  task automatic exec_cmd(input logic [2:0] op, input logic [2:0] ra,
                          input logic [2:0] rb, input logic [2:0] rc);
    logic [2:0]  eop;
    logic [35:0] r;
    logic [31:0] a, b, cv;
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    a = m_reg[ra]; b = m_reg[rb]; cv = m_reg[rc];
    eop = (op == 3'd7) ? 3'd1 : op;
    r = alu_fn(eop, a, b, imm);
    cmd_valid = 1'b1;
    cmd = {op, ra, rb, rc};
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL exec_cycle: ready=%b done=%b required 0 0", cmd_ready, done);
    end
    checks++;
    if (alu_op !== eop || alu_a !== a || alu_b !== b) begin
      errors++;
      $display("FAIL alu_drive: op=%0d a=%h b=%h required op=%0d a=%h b=%h",
               alu_op, alu_a, alu_b, eop, a, b);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_t2: done=%b required 1", done);
    end
    if (op == 3'd7) begin
      if (a == b) begin m_reg[ra] = cv; m_reg[NREG-1] = 32'd1; m_cas_ok = 1'b1; end
      else begin m_reg[NREG-1] = 32'd0; m_cas_ok = 1'b0; end
    end else begin
      m_reg[rc] = r[35:4];
      m_cas_ok = 1'b0;
    end
    m_flags = r[3:0];
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL t3: done=%b ready=%b required 0 1", done, cmd_ready);
    end
    checks++;
    if (flags !== m_flags) begin
      errors++; $display("FAIL flags op%0d: got %b required %b", op, flags, m_flags);
    end
    checks++;
    if (cas_ok !== m_cas_ok) begin
      errors++; $display("FAIL cas_ok op%0d: got %b required %b", op, cas_ok, m_cas_ok);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== m_reg[i]) begin
        errors++; $display("FAIL reg R%0d after op%0d: got %h required %h", i, op, dbg_data, m_reg[i]);
      end
    end
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [31:0] v);
    imm = v;
    exec_cmd(3'd6, 3'd0, 3'd0, r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd = {3'd0, 3'd1, 3'd2, 3'd3};
    dbg_addr = '0;
    imm = '0;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reset_hs: ready=%b done=%b required 1 0", cmd_ready, done);
    end
    checks++;
    if (alu_op !== 3'd0 || alu_a !== '0 || alu_b !== '0) begin
      errors++; $display("FAIL reset_alu: op=%0d a=%h b=%h required 0", alu_op, alu_a, alu_b);
    end
    checks++;
    if (flags !== 4'd0 || cas_ok !== 1'b0) begin
      errors++; $display("FAIL reset_flags: flags=%b cas_ok=%b required 0", flags, cas_ok);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        errors++; $display("FAIL reset_reg R%0d: got %h required 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_add();
    load_reg(3'd1, 32'd5);
    load_reg(3'd2, 32'd7);
    exec_cmd(3'd0, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 32'd12 || flags[1] !== 1'b0) begin
      errors++; $display("FAIL add: R3=%0d Z=%b required 12 0", dbg_data, flags[1]);
    end
  endtask

  task automatic test_sub();
    exec_cmd(3'd1, 3'd1, 3'd1, 3'd4);
    @(negedge clk);
    dbg_addr = 3'd4;
    #1;
    checks++;
    if (dbg_data !== 32'd0 || flags[1] !== 1'b1 || cas_ok !== 1'b0) begin
      errors++;
      $display("FAIL sub: R4=%0d Z=%b cas_ok=%b required 0 1 0", dbg_data, flags[1], cas_ok);
    end
  endtask

  task automatic test_cas();
    logic [31:0] r1, r2, r3, r7;
    load_reg(3'd1, 32'd9);
    load_reg(3'd2, 32'd9);
    load_reg(3'd3, 32'd42);
    exec_cmd(3'd7, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    dbg_addr = 3'd1; #1; r1 = dbg_data;
    dbg_addr = 3'd2; #1; r2 = dbg_data;
    dbg_addr = 3'd3; #1; r3 = dbg_data;
    dbg_addr = 3'd7; #1; r7 = dbg_data;
    checks++;
    if (r1 !== 32'd42 || r7 !== 32'd1 || cas_ok !== 1'b1 || r2 !== 32'd9 || r3 !== 32'd42) begin
      errors++;
      $display("FAIL cas_hit: R1=%0d R2=%0d R3=%0d R7=%0d ok=%b required 42 9 42 1 1",
               r1, r2, r3, r7, cas_ok);
    end
    load_reg(3'd1, 32'd9);
    load_reg(3'd2, 32'd8);
    exec_cmd(3'd7, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    dbg_addr = 3'd1; #1; r1 = dbg_data;
    dbg_addr = 3'd7; #1; r7 = dbg_data;
    checks++;
    if (r1 !== 32'd9 || r7 !== 32'd0 || cas_ok !== 1'b0) begin
      errors++; $display("FAIL cas_miss: R1=%0d R7=%0d ok=%b required 9 0 0", r1, r7, cas_ok);
    end
    // R7 == R0 == 0, so this CAS succeeds and targets the status register.
    exec_cmd(3'd7, 3'd7, 3'd0, 3'd3);
    @(negedge clk);
    dbg_addr = 3'd7; #1;
    checks++;
    if (dbg_data !== 32'd1 || cas_ok !== 1'b1) begin
      errors++; $display("FAIL cas_status_wins: R7=%0d ok=%b required 1 1", dbg_data, cas_ok);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    load_reg(3'd1, 32'd5);
    load_reg(3'd2, 32'd7);
    cmd_valid = 1'b1;
    cmd = {3'd0, 3'd1, 3'd2, 3'd3};
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_exec: done=%b ready=%b required 0 0", done, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL midrst_done: done=%b required 0", done);
    end
    model_clear();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || alu_op !== 3'd0 || alu_a !== '0 ||
        alu_b !== '0 || flags !== 4'd0 || cas_ok !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: done=%b ready=%b op=%0d a=%h b=%h flags=%b ok=%b required reset values",
               done, cmd_ready, alu_op, alu_a, alu_b, flags, cas_ok);
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        errors++; $display("FAIL midrst_reg R%0d: got %h required 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_held_valid();
    int ndone;
    load_reg(3'd1, 32'd5);
    @(negedge clk);
    ndone = 0;
    cmd_valid = 1'b1;
    cmd = {3'd0, 3'd1, 3'd3, 3'd3};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (i == 1) cmd_valid = 1'b0;
    end
    m_reg[3] = m_reg[1] + m_reg[3];
    m_flags = alu_fn(3'd0, 32'd5, 32'd0, imm) >> 0;
    m_flags = 4'(alu_fn(3'd0, 32'd5, 32'd0, imm));
    m_cas_ok = 1'b0;
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL held_valid_count: done pulses %0d required 1", ndone);
    end
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 32'd5) begin
      errors++; $display("FAIL held_valid_r3: got %0d required 5", dbg_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op, ra, rb, rc;
      op = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      rc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rb = ra;
      imm = $urandom;
      exec_cmd(op, ra, rb, rc);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cas();
    test_reset_mid();
    test_held_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
